// File: rtl/except_ctrl_pkg.sv
// Shared definitions for the MEM-stage exception/redirect controller:
// cp0 exception codes, cp0 register addresses, FSM and select encodings.
package except_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CP0_AW = 5;

    localparam logic [XLEN-1:0] EXC_NONE = 32'h0;
    localparam logic [XLEN-1:0] EXC_INT  = 32'h1;
    localparam logic [XLEN-1:0] EXC_ADEL = 32'h4;
    localparam logic [XLEN-1:0] EXC_ADES = 32'h5;
    localparam logic [XLEN-1:0] EXC_SYS  = 32'h8;
    localparam logic [XLEN-1:0] EXC_BP   = 32'h9;
    localparam logic [XLEN-1:0] EXC_RI   = 32'hA;
    localparam logic [XLEN-1:0] EXC_OV   = 32'hC;
    localparam logic [XLEN-1:0] EXC_ERET = 32'hE;

    localparam logic [CP0_AW-1:0] CP0_EPC_ADDR = 5'd14;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_FLUSH = 1'b1
    } exc_state_e;

    // Which address the winning exception reports as BadVAddr
    typedef enum logic [1:0] {
        BAD_NONE = 2'd0,
        BAD_PC   = 2'd1,
        BAD_DATA = 2'd2
    } bad_sel_e;

    typedef struct packed {
        logic if_adel;
        logic ri;
        logic sys;
        logic bp;
        logic ov;
        logic ld_adel;
        logic st_ades;
        logic eret;
    } exc_flags_t;

    // Interrupts enabled (IE), not already in exception level (EXL), some unmasked IP
    function automatic logic int_pending(input logic       ie,
                                         input logic       exl,
                                         input logic [7:0] im,
                                         input logic [7:0] ip);
        return ie & ~exl & (|(im & ip));
    endfunction

endpackage

// File: rtl/except_ctrl_prio.sv
// Combinational exception priority encoder: picks one cp0 code per cycle and
// reports which address feeds BadVAddr for the winner.
module exc_prio_enc
    import except_ctrl_pkg::*;
(
    input  exc_flags_t      i_flags,
    input  logic            i_int,
    output logic [XLEN-1:0] o_code,
    output bad_sel_e        o_bad_sel
);

    always_comb begin
        o_code    = EXC_NONE;
        o_bad_sel = BAD_NONE;
        if (i_int) begin
            o_code = EXC_INT;
        end else if (i_flags.if_adel) begin
            o_code    = EXC_ADEL;
            o_bad_sel = BAD_PC;
        end else if (i_flags.ri) begin
            o_code = EXC_RI;
        end else if (i_flags.sys) begin
            o_code = EXC_SYS;
        end else if (i_flags.bp) begin
            o_code = EXC_BP;
        end else if (i_flags.ov) begin
            o_code = EXC_OV;
        end else if (i_flags.ld_adel) begin
            o_code    = EXC_ADEL;
            o_bad_sel = BAD_DATA;
        end else if (i_flags.st_ades) begin
            o_code    = EXC_ADES;
            o_bad_sel = BAD_DATA;
        end else if (i_flags.eret) begin
            o_code = EXC_ERET;
        end
    end

endmodule

// File: rtl/except_ctrl.sv
// MEM-stage exception/redirect controller driving the cp0 exception interface,
// pipeline flush and the fetch redirect. Optional macro EXC_EPC_FWD_EN forwards
// an in-flight mtc0 EPC write to the eret target.
module except_ctrl
    import except_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR   = 32'hBFC00380,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_i,
    input  logic [31:0] mem_pc_i,
    input  logic        mem_in_delayslot_i,
    input  logic [31:0] mem_addr_i,
    input  logic        exc_if_adel_i,
    input  logic        exc_ri_i,
    input  logic        exc_sys_i,
    input  logic        exc_bp_i,
    input  logic        exc_ov_i,
    input  logic        exc_ld_adel_i,
    input  logic        exc_st_ades_i,
    input  logic        exc_eret_i,
    input  logic [31:0] cp0_status_i,
    input  logic [31:0] cp0_cause_i,
    input  logic [31:0] cp0_epc_i,
    input  logic        cp0_we_i,
    input  logic [4:0]  cp0_waddr_i,
    input  logic [31:0] cp0_wdata_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] current_inst_addr_o,
    output logic        is_in_delayslot_o,
    output logic [31:0] bad_addr_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output logic        new_pc_valid_o,
    input  logic        pc_ack_i
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    exc_state_e       r_state;
    exc_state_e       w_state_n;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_n;
    logic             r_ack_seen;
    logic             w_ack_seen_n;
    logic [XLEN-1:0]  r_new_pc;
    logic [XLEN-1:0]  w_new_pc_n;
    logic             r_flush;
    logic             w_flush_n;
    logic             r_new_pc_valid;
    logic             w_new_pc_valid_n;
    logic             r_int_pend;
    logic             w_int_pend_n;

    logic             w_int_pending;
    logic             w_int;
    exc_flags_t       w_flags;
    logic [XLEN-1:0]  w_code;
    bad_sel_e         w_bad_sel;
    logic             w_take;
    logic [XLEN-1:0]  w_epc;
    logic [XLEN-1:0]  w_redirect;
    logic             w_unused;

    assign w_int_pending = int_pending(cp0_status_i[0], cp0_status_i[1],
                                       cp0_status_i[15:8], cp0_cause_i[15:8]);
    assign w_int = w_int_pending | r_int_pend;

    assign w_flags = '{
        if_adel: exc_if_adel_i,
        ri:      exc_ri_i,
        sys:     exc_sys_i,
        bp:      exc_bp_i,
        ov:      exc_ov_i,
        ld_adel: exc_ld_adel_i,
        st_ades: exc_st_ades_i,
        eret:    exc_eret_i
    };

    exc_prio_enc u_prio (
        .i_flags   (w_flags),
        .i_int     (w_int),
        .o_code    (w_code),
        .o_bad_sel (w_bad_sel)
    );

    // Gated by rst so the cp0 interface reads as idle while reset is asserted
    assign w_take = rst & (r_state == ST_IDLE) & mem_valid_i & (w_code != EXC_NONE);

`ifdef EXC_EPC_FWD_EN
    assign w_epc = (cp0_we_i && (cp0_waddr_i == CP0_EPC_ADDR)) ? cp0_wdata_i : cp0_epc_i;
    assign w_unused = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0]};
`else
    assign w_epc = cp0_epc_i;
    assign w_unused = ^{cp0_status_i[31:16], cp0_status_i[7:2],
                        cp0_cause_i[31:16], cp0_cause_i[7:0],
                        cp0_we_i, cp0_waddr_i, cp0_wdata_i};
`endif

    assign w_redirect = (w_code == EXC_ERET) ? w_epc : EXC_VECTOR;

    // State and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_ack_seen     <= 1'b0;
            r_new_pc       <= '0;
            r_flush        <= 1'b0;
            r_new_pc_valid <= 1'b0;
            r_int_pend     <= 1'b0;
        end else begin
            r_state        <= w_state_n;
            r_cnt          <= w_cnt_n;
            r_ack_seen     <= w_ack_seen_n;
            r_new_pc       <= w_new_pc_n;
            r_flush        <= w_flush_n;
            r_new_pc_valid <= w_new_pc_valid_n;
            r_int_pend     <= w_int_pend_n;
        end
    end

    // Next state: leave FLUSH once the minimum hold has elapsed and fetch has acked
    always_comb begin
        w_state_n = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_take) begin
                    w_state_n = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if ((r_cnt == '0) && (r_ack_seen || pc_ack_i)) begin
                    w_state_n = ST_IDLE;
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Next values for counter, ack tracking, redirect target and outputs
    always_comb begin
        w_cnt_n      = r_cnt;
        w_ack_seen_n = r_ack_seen;
        w_new_pc_n   = r_new_pc;
        w_int_pend_n = r_int_pend;

        if (w_take) begin
            w_cnt_n      = CNT_LOAD;
            w_ack_seen_n = 1'b0;
            w_new_pc_n   = w_redirect;
        end else if (r_state == ST_FLUSH) begin
            if (r_cnt != '0) begin
                w_cnt_n = r_cnt - CNT_W'(1);
            end
            if (pc_ack_i && r_new_pc_valid) begin
                w_ack_seen_n = 1'b1;
            end
        end
        if (w_state_n == ST_IDLE) begin
            w_ack_seen_n = 1'b0;
        end

        w_flush_n        = (w_state_n == ST_FLUSH);
        w_new_pc_valid_n = (w_state_n == ST_FLUSH) & ~w_ack_seen_n;

        // Hold an interrupt until a real instruction can carry it
        if (w_int_pending && (!mem_valid_i || (r_state != ST_IDLE))) begin
            w_int_pend_n = 1'b1;
        end else if (w_take || !w_int_pending) begin
            w_int_pend_n = 1'b0;
        end
    end

    assign flush_o        = r_flush;
    assign new_pc_valid_o = r_new_pc_valid;
    assign new_pc_o       = r_new_pc;

    // cp0 interface is combinational; cp0 samples it on the take edge
    assign excepttype_o        = w_take ? w_code : EXC_NONE;
    assign current_inst_addr_o = rst ? mem_pc_i : '0;
    assign is_in_delayslot_o   = rst & mem_in_delayslot_i;

    always_comb begin
        bad_addr_o = '0;
        if (w_take) begin
            case (w_bad_sel)
                BAD_PC:   bad_addr_o = mem_pc_i;
                BAD_DATA: bad_addr_o = mem_addr_i;
                default:  bad_addr_o = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_except_ctrl.sv
// Directed self-checking bench for except_ctrl with hand-computed expectations.
module tb_except_ctrl;

    localparam logic [31:0] VEC = 32'hBFC00380;
    localparam logic [7:0] F_IF = 8'h80, F_RI = 8'h40, F_SYS = 8'h20, F_BP = 8'h10;
    localparam logic [7:0] F_OV = 8'h08, F_LD = 8'h04, F_ST = 8'h02, F_ERET = 8'h01;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid_i;
    logic [31:0] mem_pc_i;
    logic        mem_in_delayslot_i;
    logic [31:0] mem_addr_i;
    logic        exc_if_adel_i, exc_ri_i, exc_sys_i, exc_bp_i;
    logic        exc_ov_i, exc_ld_adel_i, exc_st_ades_i, exc_eret_i;
    logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i;
    logic        cp0_we_i;
    logic [4:0]  cp0_waddr_i;
    logic [31:0] cp0_wdata_i;
    logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, new_pc_o;
    logic        is_in_delayslot_o, flush_o, new_pc_valid_o;
    logic        pc_ack_i;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    except_ctrl #(.EXC_VECTOR(VEC), .FLUSH_CYCLES(2)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .mem_valid_i         (mem_valid_i),
        .mem_pc_i            (mem_pc_i),
        .mem_in_delayslot_i  (mem_in_delayslot_i),
        .mem_addr_i          (mem_addr_i),
        .exc_if_adel_i       (exc_if_adel_i),
        .exc_ri_i            (exc_ri_i),
        .exc_sys_i           (exc_sys_i),
        .exc_bp_i            (exc_bp_i),
        .exc_ov_i            (exc_ov_i),
        .exc_ld_adel_i       (exc_ld_adel_i),
        .exc_st_ades_i       (exc_st_ades_i),
        .exc_eret_i          (exc_eret_i),
        .cp0_status_i        (cp0_status_i),
        .cp0_cause_i         (cp0_cause_i),
        .cp0_epc_i           (cp0_epc_i),
        .cp0_we_i            (cp0_we_i),
        .cp0_waddr_i         (cp0_waddr_i),
        .cp0_wdata_i         (cp0_wdata_i),
        .excepttype_o        (excepttype_o),
        .current_inst_addr_o (current_inst_addr_o),
        .is_in_delayslot_o   (is_in_delayslot_o),
        .bad_addr_o          (bad_addr_o),
        .flush_o             (flush_o),
        .new_pc_o            (new_pc_o),
        .new_pc_valid_o      (new_pc_valid_o),
        .pc_ack_i            (pc_ack_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flags(input logic [7:0] f);
        {exc_if_adel_i, exc_ri_i, exc_sys_i, exc_bp_i,
         exc_ov_i, exc_ld_adel_i, exc_st_ades_i, exc_eret_i} = f;
    endtask

    task automatic clr_in();
        mem_valid_i = 1'b0;
        mem_in_delayslot_i = 1'b0;
        set_flags(8'h00);
        pc_ack_i = 1'b0;
        cp0_we_i = 1'b0;
    endtask

    // Ack the redirect, then wait (bounded) for the flush to end
    task automatic drain();
        int n;
        pc_ack_i = 1'b1;
        step();
        pc_ack_i = 1'b0;
        n = 0;
        while (flush_o && n < 20) begin
            step();
            n++;
        end
        chk("drain_done", 32'(flush_o), 32'h0);
    endtask

    // Present one instruction, check the take cycle and the redirect, then drain
    task automatic do_exc(input string tag, input logic [7:0] f, input logic [31:0] pc,
                          input logic [31:0] addr, input logic ds,
                          input logic [31:0] exp_code, input logic [31:0] exp_bad);
        mem_valid_i = 1'b1;
        mem_pc_i = pc;
        mem_addr_i = addr;
        mem_in_delayslot_i = ds;
        set_flags(f);
        @(negedge clk);
        chk({tag, "_code"}, excepttype_o, exp_code);
        chk({tag, "_bad"}, bad_addr_o, exp_bad);
        chk({tag, "_ds"}, 32'(is_in_delayslot_o), 32'(ds));
        chk({tag, "_cia"}, current_inst_addr_o, pc);
        step();
        clr_in();
        @(negedge clk);
        chk({tag, "_flush"}, 32'(flush_o), 32'h1);
        chk({tag, "_npc"}, new_pc_o, VEC);
        drain();
    endtask

    initial begin
        rst = 1'b0;
        clr_in();
        mem_valid_i = 1'b1;
        mem_pc_i = 32'h12345678;
        mem_addr_i = 32'h0;
        mem_in_delayslot_i = 1'b1;
        exc_sys_i = 1'b1;
        cp0_status_i = 32'h0;
        cp0_cause_i = 32'h0;
        cp0_epc_i = 32'h0;
        cp0_waddr_i = 5'd0;
        cp0_wdata_i = 32'h0;
        #12;
        chk("rst_code", excepttype_o, 32'h0);
        chk("rst_cia", current_inst_addr_o, 32'h0);
        chk("rst_ds", 32'(is_in_delayslot_o), 32'h0);
        chk("rst_flush", 32'(flush_o), 32'h0);
        chk("rst_npv", 32'(new_pc_valid_o), 32'h0);
        chk("rst_npc", new_pc_o, 32'h0);
        clr_in();
        @(negedge clk);
        rst = 1'b1;
        step();

        // Syscall; flags during FLUSH ignored; flush held the minimum two cycles
        mem_valid_i = 1'b1;
        mem_pc_i = 32'hBFC00100;
        exc_sys_i = 1'b1;
        @(negedge clk);
        chk("sys_code", excepttype_o, 32'h8);
        chk("sys_cia", current_inst_addr_o, 32'hBFC00100);
        chk("sys_flush_pre", 32'(flush_o), 32'h0);
        step();
        clr_in();
        mem_valid_i = 1'b1;
        exc_sys_i = 1'b1;
        pc_ack_i = 1'b1;
        @(negedge clk);
        chk("sys_flush", 32'(flush_o), 32'h1);
        chk("sys_npv", 32'(new_pc_valid_o), 32'h1);
        chk("sys_npc", new_pc_o, VEC);
        chk("flush_ignore", excepttype_o, 32'h0);
        step();
        clr_in();
        @(negedge clk);
        chk("flush_min", 32'(flush_o), 32'h1);
        chk("npv_after_ack", 32'(new_pc_valid_o), 32'h0);
        step();
        @(negedge clk);
        chk("sys_exit", 32'(flush_o), 32'h0);
        step();

        // Priority and BadVAddr vectors, issued back-to-back after each flush
        do_exc("ld_adel", F_LD, 32'h80000010, 32'h80000003, 1'b1, 32'h4, 32'h80000003);
        do_exc("ri_sys", F_RI | F_SYS, 32'h80000020, 32'h0, 1'b0, 32'hA, 32'h0);
        do_exc("if_ld", F_IF | F_LD, 32'hBFC00FF1, 32'h80000005, 1'b0, 32'h4, 32'hBFC00FF1);
        do_exc("st_ades", F_ST, 32'h80000030, 32'h80000102, 1'b0, 32'h5, 32'h80000102);
        do_exc("bp_ov", F_BP | F_OV, 32'h80000040, 32'h0, 1'b1, 32'h9, 32'h0);
        do_exc("ov", F_OV, 32'h80000050, 32'h0, 1'b0, 32'hC, 32'h0);

        // Interrupt during a bubble wins over overflow on the next instruction
        cp0_status_i = 32'h0000FF01;
        cp0_cause_i = 32'h00000400;
        @(negedge clk);
        chk("int_bubble", excepttype_o, 32'h0);
        step();
        mem_valid_i = 1'b1;
        mem_pc_i = 32'h80000060;
        exc_ov_i = 1'b1;
        @(negedge clk);
        chk("int_code", excepttype_o, 32'h1);
        chk("int_bad", bad_addr_o, 32'h0);
        step();
        clr_in();
        cp0_cause_i = 32'h0;
        drain();
        step();
        mem_valid_i = 1'b1;
        @(negedge clk);
        chk("int_cleared", excepttype_o, 32'h0);
        step();
        clr_in();

        // EXL masks interrupts
        cp0_status_i = 32'h0000FF03;
        cp0_cause_i = 32'h00000400;
        do_exc("int_exl", F_OV, 32'h80000070, 32'h0, 1'b0, 32'hC, 32'h0);

        // Latched interrupt survives the pending condition dropping
        cp0_status_i = 32'h0000FF01;
        step();
        cp0_cause_i = 32'h0;
        do_exc("int_latch", F_OV, 32'h80000080, 32'h0, 1'b0, 32'h1, 32'h0);
        cp0_status_i = 32'h0;
        step();

        // eret with ack delayed: valid and flush held until the fourth cycle
        cp0_epc_i = 32'hBFC00200;
        mem_valid_i = 1'b1;
        mem_pc_i = 32'h80000090;
        exc_eret_i = 1'b1;
        @(negedge clk);
        chk("eret_code", excepttype_o, 32'hE);
        step();
        clr_in();
        for (int i = 0; i < 4; i++) begin
            if (i == 3) pc_ack_i = 1'b1;
            @(negedge clk);
            chk("eret_npv", 32'(new_pc_valid_o), 32'h1);
            chk("eret_flush", 32'(flush_o), 32'h1);
            chk("eret_npc", new_pc_o, 32'hBFC00200);
            step();
        end
        pc_ack_i = 1'b0;
        @(negedge clk);
        chk("eret_exit_flush", 32'(flush_o), 32'h0);
        chk("eret_exit_npv", 32'(new_pc_valid_o), 32'h0);
        step();

        // eret alongside an mtc0 EPC write
        mem_valid_i = 1'b1;
        exc_eret_i = 1'b1;
        cp0_we_i = 1'b1;
        cp0_waddr_i = 5'd14;
        cp0_wdata_i = 32'h80001000;
        step();
        clr_in();
        @(negedge clk);
`ifdef EXC_EPC_FWD_EN
        chk("eret_fwd", new_pc_o, 32'h80001000);
`else
        chk("eret_nofwd", new_pc_o, 32'hBFC00200);
`endif
        drain();

        // Ack in the IDLE take cycle is ignored
        mem_valid_i = 1'b1;
        exc_sys_i = 1'b1;
        pc_ack_i = 1'b1;
        step();
        clr_in();
        @(negedge clk);
        chk("ack_idle_npv1", 32'(new_pc_valid_o), 32'h1);
        step();
        @(negedge clk);
        chk("ack_idle_npv2", 32'(new_pc_valid_o), 32'h1);
        drain();

        // Reset mid-FLUSH drops the redirect asynchronously
        mem_valid_i = 1'b1;
        exc_sys_i = 1'b1;
        step();
        clr_in();
        @(negedge clk);
        chk("pre_rst_flush", 32'(flush_o), 32'h1);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_flush", 32'(flush_o), 32'h0);
        chk("arst_npv", 32'(new_pc_valid_o), 32'h0);
        chk("arst_npc", new_pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        step();
        do_exc("post_rst", F_SYS, 32'hBFC00100, 32'h0, 1'b0, 32'h8, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/except_ctrl.md
Name: except_ctrl

Overview:
- Exception/redirect controller that drives the cp0 exception interface. Located at the MEM stage.
- Collects per-instruction exception flags and qualifies pending interrupts against cp0 Status/Cause. Prioritises them into one cp0 exception code per cycle.
- Drives pipeline flush and the redirect PC (exception vector or EPC for eret) to fetch through a valid/ack handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, redirect target for every exception except eret.
- FLUSH_CYCLES, 2, minimum number of cycles flush_o is held (range 1..15).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-low
- mem_valid_i  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc_i  in  32  PC of MEM instruction
- mem_in_delayslot_i  in  1  MEM instruction is in a branch delay slot
- mem_addr_i  in  32  data address of the MEM load/store
- exc_if_adel_i, exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i, exc_ld_adel_i, exc_st_ades_i, exc_eret_i  in  1 each  exception flags carried with the instruction
- cp0_status_i  in  32  cp0 Status
- cp0_cause_i  in  32  cp0 Cause
- cp0_epc_i  in  32  cp0 EPC
- cp0_we_i  in  1  mtc0 write in flight to cp0 (same cycle)
- cp0_waddr_i  in  5  its register address
- cp0_wdata_i  in  32  its data
- excepttype_o  out  32  exception code to cp0 (0 = none)
- current_inst_addr_o  out  32  PC to cp0
- is_in_delayslot_o  out  1  delay-slot flag to cp0
- bad_addr_o  out  32  BadVAddr to cp0
- flush_o  out  1  kill IF..MEM
- new_pc_o  out  32  redirect target
- new_pc_valid_o  out  1  redirect request
- pc_ack_i  in  1  fetch accepted new_pc_o

Behaviour:
- Interrupt pending: Status[0] & ~Status[1] & |(Cause[15:8] & Status[15:8]).
- Interrupt latch int_pend_q:
  - Set when pending is true and no instruction is available, i.e. mem_valid_i=0 or state≠IDLE.
  - Cleared when the interrupt is taken, or when the pending condition drops.
  - An interrupt attaches only to a valid MEM instruction.
- Priority, highest first, with the code driven on excepttype_o:
  - interrupt (pending or int_pend_q): 32'h1
  - exc_if_adel_i: 32'h4
  - exc_ri_i: 32'hA
  - exc_sys_i: 32'h8
  - exc_bp_i: 32'h9
  - exc_ov_i: 32'hC
  - exc_ld_adel_i: 32'h4
  - exc_st_ades_i: 32'h5
  - exc_eret_i: 32'hE
- Take condition: state=IDLE & mem_valid_i & (code≠0).
  - excepttype_o is combinational and nonzero only in that cycle (single-cycle pulse). cp0 samples it on the same edge.
  - Otherwise excepttype_o is 0.
- current_inst_addr_o = mem_pc_i and is_in_delayslot_o = mem_in_delayslot_i. cp0 performs the −4 adjustment itself.
- bad_addr_o:
  - mem_pc_i for fetch AdEL.
  - mem_addr_i for load AdEL or store AdES.
  - Otherwise 0.
- FSM states IDLE, FLUSH.
  - IDLE→FLUSH on take.
  - Registered on that edge: new_pc_q (cp0 EPC for eret, else EXC_VECTOR) and cnt = FLUSH_CYCLES−1. ack_seen is cleared.
  - In FLUSH:
    - flush_o=1, new_pc_valid_o = ~ack_seen.
    - cnt decrements to 0 and saturates there.
    - ack_seen is set on pc_ack_i.
    - No new take; all flags are ignored because those instructions are being killed.
  - FLUSH→IDLE when cnt==0 and (ack_seen | pc_ack_i).
  - flush_o and new_pc_valid_o are registered outputs, so they assert the cycle after take.
- Back-to-back: a take can occur in the first IDLE cycle after FLUSH exits.
- pc_ack_i while new_pc_valid_o=0 is ignored.
- Reset (async, rst=0) returns immediately to this state:
  - state=IDLE, int_pend_q=0, cnt=0, ack_seen=0
  - flush_o=0, new_pc_valid_o=0, new_pc_o=0
  - excepttype_o=0, current_inst_addr_o=0, is_in_delayslot_o=0, bad_addr_o=0 (outputs gated)
  - Reset mid-FLUSH abandons the redirect.

Optional Feature:
- EXC_EPC_FWD_EN defined: the eret target uses cp0_wdata_i when cp0_we_i=1 and cp0_waddr_i=14 in the take cycle, otherwise cp0_epc_i.
- Undefined: the target is always cp0_epc_i. Software must separate mtc0 EPC from eret.

Decomposition:
- Shared package/header holds:
  - exception codes EXC_INT, EXC_ADEL, EXC_ADES, EXC_SYS, EXC_BP, EXC_RI, EXC_OV, EXC_ERET
  - CP0 register address EPC=14
  - FSM state encodings
- One sub-module: exc_prio_enc. It is combinational: flags plus interrupt in, 32-bit code and a data-address select out.

Test Plan:
- Syscall at PC 0xBFC00100, not in delay slot → one-cycle excepttype_o=0x8, current_inst_addr_o=0xBFC00100; next cycle flush_o=1, new_pc_o=0xBFC00380.
- Load AdEL, mem_addr_i=0x80000003, delay slot=1 → excepttype_o=0x4, bad_addr_o=0x80000003, is_in_delayslot_o=1.
- Status=0x0000FF01, Cause[10]=1 during a bubble, then valid instruction with exc_ov_i=1 → excepttype_o=0x1 (interrupt wins), int_pend_q cleared.
- eret with cp0_epc_i=0xBFC00200 and pc_ack_i delayed 4 cycles → new_pc_valid_o held 4 cycles; flush_o stays high until ack; FSM returns to IDLE on ack.
- With EXC_EPC_FWD_EN: eret with mtc0 EPC=0x80001000 in the same cycle → new_pc_o=0x80001000.
- rst=0 during FLUSH → flush_o and new_pc_valid_o drop asynchronously; a subsequent syscall is taken normally.
